// File: rtl/pixel_frame_buffer.sv
// Double-buffered greyscale frame store feeding the TLC5941 driver; buffers swap only on frame_tick.
// Define PFB_GAMMA_EN for square-law (gamma ~2) expansion instead of linear byte-to-12-bit expansion.
module pixel_frame_buffer #(
    parameter int unsigned ROWS  = 6,
    parameter int unsigned WORDS = 96
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    input  logic        frame_tick,
    input  logic [2:0]  rd_row,
    input  logic [6:0]  rd_word,
    output logic [11:0] rd_data,
    output logic        front_sel,
    output logic [7:0]  repeat_cnt
);

    localparam int unsigned FRAME = ROWS * WORDS;
    localparam logic [9:0]  LAST  = 10'(FRAME - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

    state_e      state;
    logic [9:0]  wr_addr;
    logic        has_frame;
    logic [11:0] mem [2048];

    logic        accept;
    logic        wr_en;
    logic [9:0]  wr_idx;
    logic [11:0] gval;
    logic [9:0]  rd_addr;
    logic        rd_ok;

    always_comb begin
        accept  = in_valid && in_ready;
        wr_en   = accept && ((state == StLoad) || ((state == StIdle) && in_sof));
        wr_idx  = in_sof ? 10'd0 : wr_addr;
        rd_ok   = (rd_row < 3'(ROWS)) && (rd_word < 7'(WORDS));
        rd_addr = 10'(rd_row) * 10'(WORDS) + 10'(rd_word);
    end

`ifdef PFB_GAMMA_EN
    logic [15:0] sq;
    always_comb begin
        sq   = {8'd0, in_data} * {8'd0, in_data};
        gval = 12'(sq >> 4);
    end
`else
    always_comb begin
        gval = {in_data, in_data[7:4]};
    end
`endif

    // Back buffer is always the half not currently shown.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[{~front_sel, wr_idx}] <= gval;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= (has_frame && rd_ok) ? mem[{front_sel, rd_addr}] : 12'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            wr_addr    <= '0;
            in_ready   <= 1'b0;
            front_sel  <= 1'b0;
            has_frame  <= 1'b0;
            repeat_cnt <= '0;
        end else begin
            // A tick without a complete back frame re-shows the current front frame.
            if (frame_tick && (state != StFull) && (repeat_cnt != 8'hFF)) begin
                repeat_cnt <= repeat_cnt + 8'd1;
            end
            unique case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (accept && in_sof) begin
                        wr_addr <= 10'd1;
                        state   <= StLoad;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (in_sof) begin
                            wr_addr <= 10'd1;
                        end else if (wr_addr == LAST) begin
                            wr_addr  <= '0;
                            in_ready <= 1'b0;
                            state    <= StFull;
                        end else begin
                            wr_addr <= wr_addr + 10'd1;
                        end
                    end
                end
                StFull: begin
                    if (frame_tick) begin
                        front_sel <= ~front_sel;
                        has_frame <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Randomised bench for pixel_frame_buffer against a frame-level reference model.
module tb_pixel_frame_buffer;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic        frame_tick;
    logic [2:0]  rd_row;
    logic [6:0]  rd_word;
    logic [11:0] rd_data;
    logic        front_sel;
    logic [7:0]  repeat_cnt;

    pixel_frame_buffer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .frame_tick (frame_tick),
        .rd_row     (rd_row),
        .rd_word    (rd_word),
        .rd_data    (rd_data),
        .front_sel  (front_sel),
        .repeat_cnt (repeat_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: shown frame, frame being collected, and bookkeeping.
    int m_front [576];
    int m_pend  [576];
    int m_cnt;
    bit m_full;
    bit m_ready;
    bit m_has;
    bit m_fsel;
    int m_rep;
    int m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp,
                     exp, $time);
        end
    endtask

    function automatic int g(input int v);
`ifdef PFB_GAMMA_EN
        return (v * v) / 16;
`else
        return v * 16 + v / 16;
`endif
    endfunction

    task automatic m_reset();
        m_cnt   = 0;
        m_full  = 0;
        m_ready = 0;
        m_has   = 0;
        m_fsel  = 0;
        m_rep   = 0;
        m_rd    = 0;
    endtask

    task automatic step(input bit v, input bit s, input logic [7:0] d, input bit t,
                        input int row, input int word);
        bit acc;
        in_valid   = v;
        in_sof     = s;
        in_data    = d;
        frame_tick = t;
        rd_row     = 3'(row);
        rd_word    = 7'(word);
        @(posedge clock);
        acc  = v && m_ready;
        m_rd = (m_has && row < 6 && word < 96) ? m_front[row * 96 + word] : 0;
        if (t) begin
            if (m_full) begin
                m_front = m_pend;
                m_has   = 1;
                m_full  = 0;
                m_cnt   = 0;
                m_fsel  = !m_fsel;
            end else if (m_rep < 255) begin
                m_rep++;
            end
        end
        if (acc) begin
            if (s) begin
                m_pend[0] = g(int'(d));
                m_cnt     = 1;
            end else if (m_cnt > 0) begin
                m_pend[m_cnt] = g(int'(d));
                m_cnt++;
                if (m_cnt == 576) m_full = 1;
            end
        end
        m_ready = !m_full;
        #1;
        check("rd_data", 32'(rd_data), 32'(m_rd));
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("front_sel", 32'(front_sel), 32'(m_fsel));
        check("repeat_cnt", 32'(repeat_cnt), 32'(m_rep));
    endtask

    task automatic idle(input int n, input bit t);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'd0, t, int'($urandom_range(0, 7)), int'($urandom_range(0, 127)));
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit s, input bit t);
        bit done;
        bit v;
        bit rdy;
        int tries;
        done  = 0;
        tries = 0;
        while (!done) begin
            v   = (tries > 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rdy = m_ready;
            step(v, s, d, t && v && rdy, int'($urandom_range(0, 7)), int'($urandom_range(0, 127)));
            tries++;
            if (v && rdy) begin
                done = 1;
            end else if (tries > 200) begin
                n_chk++;
                n_bad++;
                $display("FAIL send_bound: byte not accepted after %0d cycles", tries);
                done = 1;
            end
        end
    endtask

    // mode 0: addr[7:0], mode 1: 0xFF, mode 2: random
    task automatic send_frame(input int mode, input int n, input bit sof_first, input bit tick_last);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hFF : 8'($urandom);
            send_byte(d, sof_first && (i == 0), tick_last && (i == n - 1));
        end
    endtask

    initial begin
        in_data    = '0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        frame_tick = 1'b0;
        rd_row     = '0;
        rd_word    = '0;
        reset_n    = 1'b1;
        m_reset();
        #2 reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_front_sel", 32'(front_sel), 32'd0);
        check("rst_repeat_cnt", 32'(repeat_cnt), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 8'd0, 1'b0, 0, 0);
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // Full ramp frame, then valid held high while full, then swap.
        send_frame(0, 576, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 1'b0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)));
        end
        idle(1, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1, 5);
`ifdef PFB_GAMMA_EN
        check("rd_1_5", 32'(rd_data), 32'h27D);
`else
        check("rd_1_5", 32'(rd_data), 32'h656);
`endif
        check("front_after_swap", 32'(front_sel), 32'd1);
        idle(40, 1'b0);

        idle(3, 1'b1);
        check("repeat_3", 32'(repeat_cnt), 32'd3);
        idle(300, 1'b1);
        check("repeat_sat", 32'(repeat_cnt), 32'd255);

        // Partial frame abandoned by a new sof.
        send_frame(0, 200, 1'b1, 1'b0);
        send_frame(1, 576, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0, 5, 95);
`ifdef PFB_GAMMA_EN
        check("rd_5_95", 32'(rd_data), 32'hFE0);
`else
        check("rd_5_95", 32'(rd_data), 32'hFFF);
`endif
        idle(60, 1'b0);

        // Tick coinciding with the last accept counts as a repeat.
        send_frame(2, 576, 1'b1, 1'b1);
        idle(5, 1'b0);
        idle(1, 1'b1);
        idle(40, 1'b0);

        // Reset in the middle of loading.
        send_frame(2, 300, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        m_reset();
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_front_sel", 32'(front_sel), 32'd0);
        check("midrst_repeat_cnt", 32'(repeat_cnt), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 8'($urandom), 1'b0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)));
        end
        idle(1, 1'b1);
        check("midrst_no_swap", 32'(front_sel), 32'd0);
        send_frame(2, 576, 1'b1, 1'b0);
        idle(1, 1'b1);
        idle(30, 1'b0);

        // Free-running random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 400) == 0, 8'($urandom),
                 $urandom_range(0, 150) == 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
